id_queue_decode: RTL

Parametrised RV32I decode stage with a DEPTH-entry instruction queue, a registered decode output with valid/ready handshake, and a register-pending scoreboard that stalls on RAW/WAW hazards. Sits between IF and EX. It replaces the combinational decoder with a buffered stage that absorbs fetch bursts, decouples IF from EX back-pressure, and supports branch flush.

---
 rtl/id_queue_decode.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/id_queue_decode.sv
// RV32I decode stage: DEPTH-entry fetch queue, combinational head decode,
// register-pending scoreboard for RAW/WAW stalls and a registered EX-side output.
module id_queue_decode #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_ins,
  input  logic             flush_in,
  output logic             read_flag_1,
  output logic             read_flag_2,
  output logic [4:0]       reg_read_1,
  output logic [4:0]       reg_read_2,
  input  logic [31:0]      read_data_1,
  input  logic [31:0]      read_data_2,
  input  logic             wb_valid_in,
  input  logic [4:0]       wb_rd_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      imm,
  output logic [31:0]      r1_data,
  output logic [31:0]      r2_data,
  output logic [4:0]       r1_addr,
  output logic [4:0]       r2_addr,
  output logic [4:0]       rd_addr,
  output logic [6:0]       ins_type,
  output logic [2:0]       ins_details,
  output logic             ins_diff,
  output logic             illegal,
  output logic [PTR_W:0]   count
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_IMM    = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [31:0]    pc_mem_q  [DEPTH];
  logic [31:0]    ins_mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0] count_q, count_d;
  logic [31:0]    pend_q, pend_d;
  logic           ov_q, ov_d;

  logic [31:0] h_pc, h_ins;
  logic        head_valid, push, adv, hazard;
  opcode_e     opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

  logic [31:0] d_imm, d_r1_data, d_r2_data;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [2:0]  d_det;
  logic        d_f1, d_f2, d_diff, d_ill;

  logic [31:0] out_pc_q, imm_q, r1_data_q, r2_data_q;
  logic [4:0]  r1_addr_q, r2_addr_q, rd_addr_q;
  logic [6:0]  ins_type_q;
  logic [2:0]  ins_details_q;
  logic        ins_diff_q, illegal_q;

  assign h_pc       = pc_mem_q[head_q];
  assign h_ins      = ins_mem_q[head_q];
  assign head_valid = (count_q != '0);
  assign opc        = opcode_e'(h_ins[6:0]);
  assign f3         = h_ins[14:12];
  assign f7         = h_ins[31:25];
  assign i_imm      = {{20{h_ins[31]}}, h_ins[31:20]};
  assign s_imm      = {{20{h_ins[31]}}, h_ins[31:25], h_ins[11:7]};
  assign b_imm      = {{19{h_ins[31]}}, h_ins[31], h_ins[7], h_ins[30:25], h_ins[11:8], 1'b0};
  assign u_imm      = {h_ins[31:12], 12'h000};
  assign j_imm      = {{11{h_ins[31]}}, h_ins[31], h_ins[19:12], h_ins[20], h_ins[30:21], 1'b0};

  always_comb begin
    d_imm  = '0;
    d_rs1  = '0;
    d_rs2  = '0;
    d_rd   = '0;
    d_det  = '0;
    d_f1   = 1'b0;
    d_f2   = 1'b0;
    d_diff = 1'b0;
    d_ill  = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        d_imm = u_imm;
        d_rd  = h_ins[11:7];
      end
      OPC_JAL: begin
        d_imm = j_imm;
        d_rd  = h_ins[11:7];
      end
      OPC_JALR, OPC_LOAD, OPC_IMM: begin
        d_imm  = i_imm;
        d_f1   = 1'b1;
        d_rs1  = h_ins[19:15];
        d_rd   = h_ins[11:7];
        d_det  = f3;
        d_diff = (opc == OPC_IMM) && (f3 == 3'b101) && h_ins[30];
      end
      OPC_BRANCH, OPC_STORE: begin
        d_imm = (opc == OPC_BRANCH) ? b_imm : s_imm;
        d_f1  = 1'b1;
        d_f2  = 1'b1;
        d_rs1 = h_ins[19:15];
        d_rs2 = h_ins[24:20];
        d_det = f3;
      end
      OPC_OP: begin
        d_det  = f3;
        d_diff = h_ins[30];
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
          d_f1  = 1'b1;
          d_f2  = 1'b1;
          d_rs1 = h_ins[19:15];
          d_rs2 = h_ins[24:20];
          d_rd  = h_ins[11:7];
        end else begin
          d_ill = 1'b1;
        end
      end
      default: d_ill = 1'b1;
    endcase
  end

  // Unused ports have address 0, so the x0 test also zeroes their data.
  assign d_r1_data = (d_rs1 != '0) ? read_data_1 : '0;
  assign d_r2_data = (d_rs2 != '0) ? read_data_2 : '0;

  assign read_flag_1 = head_valid & d_f1;
  assign read_flag_2 = head_valid & d_f2;
  assign reg_read_1  = head_valid ? d_rs1 : '0;
  assign reg_read_2  = head_valid ? d_rs2 : '0;

  assign hazard   = (d_f1 & pend_q[d_rs1]) | (d_f2 & pend_q[d_rs2]) |
                    ((d_rd != '0) & pend_q[d_rd]);
  assign in_ready = rst_in & rdy_in & (count_q != FULL);
  assign push     = in_valid & in_ready & ~flush_in;
  assign adv      = rdy_in & ~flush_in & head_valid & ~hazard & (~ov_q | out_ready);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pend_d  = pend_q;
    ov_d    = ov_q;
    if (rdy_in) begin
      if (wb_valid_in) pend_d[wb_rd_in] = 1'b0;
      if (flush_in) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        ov_d    = 1'b0;
        // An un-accepted output never reaches EX, so nothing will write it back.
        if (ov_q && !out_ready) pend_d[rd_addr_q] = 1'b0;
      end else begin
        if (push) tail_d = tail_q + 1'b1;
        if (adv)  head_d = head_q + 1'b1;
        count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(adv);
        if (adv) begin
          ov_d         = 1'b1;
          pend_d[d_rd] = 1'b1;
        end else if (out_ready) begin
          ov_d = 1'b0;
        end
      end
      pend_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      pc_mem_q[tail_q]  <= in_pc;
      ins_mem_q[tail_q] <= in_ins;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
      ov_q    <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      ov_q    <= ov_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      out_pc_q      <= '0;
      imm_q         <= '0;
      r1_data_q     <= '0;
      r2_data_q     <= '0;
      r1_addr_q     <= '0;
      r2_addr_q     <= '0;
      rd_addr_q     <= '0;
      ins_type_q    <= '0;
      ins_details_q <= '0;
      ins_diff_q    <= 1'b0;
      illegal_q     <= 1'b0;
    end else if (adv) begin
      out_pc_q      <= h_pc;
      imm_q         <= d_imm;
      r1_data_q     <= d_r1_data;
      r2_data_q     <= d_r2_data;
      r1_addr_q     <= d_rs1;
      r2_addr_q     <= d_rs2;
      rd_addr_q     <= d_rd;
      ins_type_q    <= h_ins[6:0];
      ins_details_q <= d_det;
      ins_diff_q    <= d_diff;
      illegal_q     <= d_ill;
    end
  end

  assign out_valid   = ov_q;
  assign out_pc      = out_pc_q;
  assign imm         = imm_q;
  assign r1_data     = r1_data_q;
  assign r2_data     = r2_data_q;
  assign r1_addr     = r1_addr_q;
  assign r2_addr     = r2_addr_q;
  assign rd_addr     = rd_addr_q;
  assign ins_type    = ins_type_q;
  assign ins_details = ins_details_q;
  assign ins_diff    = ins_diff_q;
  assign illegal     = illegal_q;
  assign count       = count_q;

endmodule
